// File: rtl/spike_vote_counter_pkg.sv
// Shared constants for the spiking classifier: model dimensions, vote-counter
// defaults and the vote-counter FSM state encoding.
package spike_vote_counter_pkg;

  localparam int unsigned IN_DIM  = 784;
  localparam int unsigned HID_DIM = 441;
  localparam int unsigned OUT_DIM = 10;

  localparam int unsigned DEF_NUM_CLASSES = OUT_DIM;
  localparam int unsigned DEF_ITER_NUM    = 30;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_CLS_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ARGMAX,
    S_DONE
  } state_t;

endpackage

// File: rtl/vote_argmax.sv
// Sequential arg-max over the vote counters: one class per cycle, strict
// greater-than so ties keep the lowest index.
module vote_argmax
  import spike_vote_counter_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned CLS_W       = DEF_CLS_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] cand_val,
  output logic [CLS_W-1:0] scan_idx,
  output logic             last,
  output logic [CLS_W-1:0] label,
  output logic [CNT_W-1:0] max_count
);

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

  logic [CLS_W-1:0] idx_q, idx_d;
  logic [CLS_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_val_q, best_val_d;
  logic [CLS_W-1:0] label_q, label_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             take;

  always_comb begin
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    label_d    = label_q;
    max_d      = max_q;
    take       = cand_val > best_val_q;
    last       = en && (idx_q == LAST_IDX);
    if (clear) begin
      idx_d      = '0;
      best_idx_d = '0;
      best_val_d = '0;
      label_d    = '0;
      max_d      = '0;
    end else if (en) begin
      if (take) begin
        best_idx_d = idx_q;
        best_val_d = cand_val;
      end
      // The final comparison's winner is published in the same edge.
      if (idx_q == LAST_IDX) begin
        label_d = best_idx_d;
        max_d   = best_val_d;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      label_q    <= '0;
      max_q      <= '0;
    end else begin
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      label_q    <= label_d;
      max_q      <= max_d;
    end
  end

  assign scan_idx  = idx_q;
  assign label     = label_q;
  assign max_count = max_q;

endmodule

// File: rtl/spike_vote_counter.sv
// Per-class spike vote counter: accumulates classifier spikes over ITER_NUM
// iterations, then scans for the winning class.
module spike_vote_counter
  import spike_vote_counter_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int unsigned ITER_NUM    = DEF_ITER_NUM,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned CLS_W       = DEF_CLS_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             spike_valid,
  input  logic             spike,
  input  logic [CLS_W-1:0] class_id,
  input  logic [CLS_W-1:0] rd_class,
  output logic [CNT_W-1:0] rd_count,
  output logic             busy,
  output logic             done,
  output logic [CLS_W-1:0] label,
  output logic [CNT_W-1:0] max_count,
  output logic             class_err
);

  localparam int unsigned      ITER_W    = $clog2(ITER_NUM + 1);
  localparam logic [CLS_W:0]   NC_EXT    = (CLS_W + 1)'(NUM_CLASSES);
  localparam logic [CLS_W-1:0] LAST_CLS  = CLS_W'(NUM_CLASSES - 1);
  localparam logic [ITER_W-1:0] ITER_END = ITER_W'(ITER_NUM);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0]  cnt_d [NUM_CLASSES];
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              class_err_q, class_err_d;
  logic              id_ok;
  logic              scan_en, scan_last;
  logic [CLS_W-1:0]  scan_idx;
  logic [CNT_W-1:0]  scan_val;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    iter_d      = iter_q;
    class_err_d = class_err_q;
    id_ok       = {1'b0, class_id} < NC_EXT;
    if (start) begin
      state_d     = S_ACCUM;
      iter_d      = '0;
      class_err_d = 1'b0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_d[i] = '0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (spike_valid) begin
            if (!id_ok) begin
              class_err_d = 1'b1;
            end else begin
              for (int unsigned i = 0; i < NUM_CLASSES; i++)
                if (spike && class_id == CLS_W'(i) && cnt_q[i] != '1)
                  cnt_d[i] = cnt_q[i] + 1'b1;
              // The highest class closes an iteration.
              if (class_id == LAST_CLS) begin
                iter_d = iter_q + 1'b1;
                if (iter_d == ITER_END) state_d = S_ARGMAX;
              end
            end
          end
        end
        S_ARGMAX: if (scan_last) state_d = S_DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    scan_val = '0;
    rd_count = '0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx == CLS_W'(i)) scan_val = cnt_q[i];
      if (rd_class == CLS_W'(i)) rd_count = cnt_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      iter_q      <= '0;
      class_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      class_err_q <= class_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign scan_en = (state_q == S_ARGMAX);

  vote_argmax #(
    .NUM_CLASSES(NUM_CLASSES),
    .CNT_W      (CNT_W),
    .CLS_W      (CLS_W)
  ) u_argmax (
    .clock    (clock),
    .reset    (reset),
    .clear    (start),
    .en       (scan_en),
    .cand_val (scan_val),
    .scan_idx (scan_idx),
    .last     (scan_last),
    .label    (label),
    .max_count(max_count)
  );

  assign busy      = (state_q == S_ACCUM) || (state_q == S_ARGMAX);
  assign done      = (state_q == S_DONE);
  assign class_err = class_err_q;

endmodule

// File: tb/tb_spike_vote_counter.sv
// Directed bench for spike_vote_counter: vote tables plus multi-cycle corner
// sequences (class errors, reset abort, restart, saturation).
module tb_spike_vote_counter;

  logic       clock = 1'b0;
  logic       reset, start, spike_valid, spike;
  logic [3:0] class_id, rd_class, label;
  logic [7:0] rd_count, max_count;
  logic       busy, done, class_err;

  logic       start2, sv2, spk2;
  logic [3:0] cid2, rd2, rd_count2, label2, max2;
  logic       busy2, done2, err2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  spike_vote_counter dut (
    .clock(clock), .reset(reset), .start(start), .spike_valid(spike_valid),
    .spike(spike), .class_id(class_id), .rd_class(rd_class), .rd_count(rd_count),
    .busy(busy), .done(done), .label(label), .max_count(max_count),
    .class_err(class_err)
  );

  spike_vote_counter #(.CNT_W(4), .ITER_NUM(20)) dut_sat (
    .clock(clock), .reset(reset), .start(start2), .spike_valid(sv2),
    .spike(spk2), .class_id(cid2), .rd_class(rd2), .rd_count(rd_count2),
    .busy(busy2), .done(done2), .label(label2), .max_count(max2),
    .class_err(err2)
  );

  typedef struct packed {
    logic [9:0][4:0] fire;  // iterations in which each class fires
    logic [3:0]      exp_label;
    logic [7:0]      exp_max;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input int c, input bit s);
    class_id    = 4'(c);
    spike       = s;
    spike_valid = 1'b1;
    step();
    spike_valid = 1'b0;
    spike       = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    check(name, lat, 10);
  endtask

  task automatic read_cnt(input int c, output logic [31:0] v);
    rd_class = 4'(c);
    #1;
    v = 32'(rd_count);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          sum;
    bit          seen;

    vecs[0] = '0; vecs[0].fire[7] = 30; vecs[0].exp_label = 7; vecs[0].exp_max = 30;
    vecs[1] = '0;
    vecs[1].fire[0] = 5;  vecs[1].fire[1] = 11; vecs[1].fire[2] = 12; vecs[1].fire[4] = 7;
    vecs[1].fire[5] = 12; vecs[1].fire[6] = 11; vecs[1].fire[7] = 1;  vecs[1].fire[8] = 3;
    vecs[1].fire[9] = 10; vecs[1].exp_label = 2; vecs[1].exp_max = 12;
    vecs[2] = '0; vecs[2].exp_label = 0; vecs[2].exp_max = 0;
    vecs[3] = '0; vecs[3].fire[0] = 19; vecs[3].fire[4] = 18; vecs[3].fire[9] = 20;
    vecs[3].exp_label = 9; vecs[3].exp_max = 20;
    vecs[4] = '0;
    for (int c = 0; c < 10; c++) vecs[4].fire[c] = 30;
    vecs[4].exp_label = 0; vecs[4].exp_max = 30;

    reset = 1'b0; start = 1'b0; spike_valid = 1'b0; spike = 1'b0;
    class_id = '0; rd_class = 4'd7;
    start2 = 1'b0; sv2 = 1'b0; spk2 = 1'b0; cid2 = '0; rd2 = 4'd3;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_label", label, 0);
    check("reset_max", max_count, 0);
    check("reset_err", class_err, 0);
    check("reset_rd", rd_count, 0);
    reset = 1'b1;
    step();

    for (int v_i = 0; v_i < 5; v_i++) begin
      do_start();
      check($sformatf("v%0d_busy", v_i), busy, 1);
      for (int it = 0; it < 30; it++)
        for (int c = 0; c < 10; c++)
          feed(c, it < int'(vecs[v_i].fire[c]));
      wait_done($sformatf("v%0d_latency", v_i));
      check($sformatf("v%0d_label", v_i), label, vecs[v_i].exp_label);
      check($sformatf("v%0d_max", v_i), max_count, vecs[v_i].exp_max);
      check($sformatf("v%0d_busy_done", v_i), busy, 0);
      for (int c = 0; c < 10; c++) begin
        read_cnt(c, v);
        check($sformatf("v%0d_rd%0d", v_i, c), v, 32'(vecs[v_i].fire[c]));
      end
    end

    rd_class = 4'd15; #1;
    check("rd_oob15", rd_count, 0);
    rd_class = 4'd10; #1;
    check("rd_oob10", rd_count, 0);

    // Invalid class ids during accumulation
    do_start();
    check("err_cleared", class_err, 0);
    feed(12, 1'b1);
    check("err_set12", class_err, 1);
    feed(10, 1'b1);
    check("err_set10", class_err, 1);
    sum = 0;
    for (int c = 0; c < 10; c++) begin
      read_cnt(c, v);
      sum += int'(v);
    end
    check("err_no_count", sum, 0);
    for (int it = 0; it < 30; it++) feed(9, 1'b0);
    wait_done("err_latency");
    check("err_label", label, 0);
    check("err_max", max_count, 0);
    check("err_sticky", class_err, 1);

    // Spikes outside ACCUM are ignored
    do_start();
    check("restart_err_clr", class_err, 0);
    for (int it = 0; it < 30; it++) feed(9, 1'b1);
    wait_done("c9_latency");
    check("c9_label", label, 9);
    check("c9_max", max_count, 30);
    feed(12, 1'b1);
    feed(9, 1'b1);
    check("done_err_ignored", class_err, 0);
    check("done_hold", done, 1);
    read_cnt(9, v);
    check("done_rd9", v, 30);

    // Start mid-ACCUM with a concurrent spike on the iteration-closing class
    do_start();
    for (int it = 0; it < 5; it++)
      for (int c = 0; c < 10; c++) feed(c, c == 3);
    start = 1'b1; spike_valid = 1'b1; class_id = 4'd9; spike = 1'b1;
    step();
    start = 1'b0; spike_valid = 1'b0; spike = 1'b0;
    read_cnt(3, v);
    check("restart_rd3", v, 0);
    read_cnt(9, v);
    check("restart_rd9", v, 0);
    for (int it = 0; it < 30; it++)
      for (int c = 0; c < 10; c++) feed(c, c == 4);
    wait_done("restart_latency");
    check("restart_label", label, 4);
    check("restart_max", max_count, 30);
    read_cnt(9, v);
    check("restart_rd9_end", v, 0);

    // Saturating counters on the narrow instance
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int it = 0; it < 20; it++)
      for (int c = 0; c < 10; c++) begin
        cid2 = 4'(c); spk2 = (c == 3); sv2 = 1'b1;
        step();
      end
    sv2 = 1'b0; spk2 = 1'b0;
    begin
      int lat = 0;
      while (!done2 && lat < 40) begin step(); lat++; end
      check("sat_latency", lat, 10);
    end
    rd2 = 4'd3; #1;
    check("sat_rd3", rd_count2, 15);
    check("sat_label", label2, 3);
    check("sat_max", max2, 15);

    // Asynchronous reset at iteration 15 aborts the run
    do_start();
    for (int it = 0; it < 15; it++)
      for (int c = 0; c < 10; c++) feed(c, c == 7);
    read_cnt(7, v);
    check("pre_reset_rd7", v, 15);
    #1 reset = 1'b0;
    #1;
    check("abort_rd7", rd_count, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_label", label, 0);
    check("abort_max", max_count, 0);
    check("abort_err", class_err, 0);
    step();
    reset = 1'b1;
    step();
    seen = 1'b0;
    for (int it = 0; it < 15; it++)
      for (int c = 0; c < 10; c++) begin
        feed(c, c == 7);
        if (done) seen = 1'b1;
      end
    repeat (30) begin
      step();
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    check("abort_idle", busy, 0);
    read_cnt(7, v);
    check("abort_idle_rd7", v, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spike_vote_counter.md
SPIKE_VOTE_COUNTER -- requirements
Module: spike_vote_counter

Interface
REQ-001 Parameter NUM_CLASSES, default 10: number of classifier outputs (spike classes).
REQ-002 Parameter ITER_NUM, default 30: inference iterations accumulated per image.
REQ-003 Parameter CNT_W, default 8: width of each per-class spike counter.
REQ-004 Parameter CLS_W, default 4: width of class indices.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse: clears all counters and begins accumulation for a new image.
REQ-008 spike_valid  input  1  spike and class_id are valid this cycle.
REQ-009 spike  input  1  classifier spike result for class_id (1 = fired).
REQ-010 class_id  input  CLS_W  class index of the current spike, 0..NUM_CLASSES-1.
REQ-011 rd_class  input  CLS_W  combinational read address into the counter array.
REQ-012 rd_count  output  CNT_W  counter value of rd_class; 0 if rd_class >= NUM_CLASSES.
REQ-013 busy  output  1  high in ACCUM and ARGMAX states.
REQ-014 done  output  1  level, high in DONE state.
REQ-015 label  output  CLS_W  winning class index, valid while done is high.
REQ-016 max_count  output  CNT_W  spike count of the winning class, valid while done is high.
REQ-017 class_err  output  1  sticky flag: spike_valid seen with class_id >= NUM_CLASSES since last start.

Function
REQ-018 FSM states IDLE, ACCUM, ARGMAX, DONE; reset enters IDLE.
REQ-019 start in any state: next edge clears all counters, iteration counter, class_err, label, max_count; state becomes ACCUM.
REQ-020 spike_valid in the same cycle as start is ignored.
REQ-021 ACCUM: spike_valid with valid class_id and spike=1 increments counter[class_id] by 1, saturating at 2^CNT_W-1.
REQ-022 ACCUM: spike_valid with class_id = NUM_CLASSES-1 (any spike value) increments the iteration counter.
REQ-023 ACCUM: spike_valid with class_id >= NUM_CLASSES changes no counter and sets class_err.
REQ-024 The edge where the iteration counter reaches ITER_NUM moves the state to ARGMAX with scan index 0; that edge's spike is counted first.
REQ-025 ARGMAX: one class compared per cycle, index 0..NUM_CLASSES-1; the candidate replaces best only if strictly greater; ties resolve to the lowest index.
REQ-026 The edge comparing index NUM_CLASSES-1 registers label/max_count and enters DONE; done rises NUM_CLASSES cycles (10 by default) after the final spike_valid edge.
REQ-027 spike_valid outside ACCUM is ignored and does not set class_err.
REQ-028 DONE holds label, max_count and counters until the next start; rd_count remains readable in every state.
REQ-029 All-zero counters produce label=0, max_count=0.

Reset
REQ-030 Asynchronous assertion (reset=0): state=IDLE; counters, iteration counter, scan index, label, max_count, class_err, busy, done all 0.
REQ-031 Reset mid-ACCUM or mid-ARGMAX aborts without producing done; release is synchronous to clock.

Structure
REQ-032 The shared package holds the FSM state encoding and the NUM_CLASSES/ITER_NUM/CNT_W defaults, alongside the existing model-dimension constants (784/441/10).
REQ-033 One sub-module, vote_argmax, implements the sequential max-scan (REQ-025/026); the counter array and FSM stay in spike_vote_counter.

Verification
REQ-034 ITER_NUM=30. After start, each iteration fires only class 7. Required: done after final iteration + 10 cycles; label=7; max_count=30; rd_count(7)=30; all other counts 0.
REQ-035 Classes 2 and 5 both fire 12 times, all others fewer. Required: label=2 (tie goes to the lowest index), max_count=12.
REQ-036 CNT_W=4, ITER_NUM=20, class 3 fires every iteration. Required: counter[3] saturates at 15; label=3.
REQ-037 class_id=12 with spike_valid during ACCUM. Required: class_err=1; no counter changes; iteration count unaffected.
REQ-038 reset=0 at iteration 15. Required: all outputs 0 immediately; state IDLE; done never asserts. A second case: start mid-ACCUM restarts the run with cleared counters, and a spike given in the start cycle is not counted.
